// File: rtl/bp_fe_ras_pkg.sv
// Shared types for the front-end return address stack.
// Defines the checkpoint struct macro and the stack op decoder.
`ifndef BP_FE_RAS_PKG_SV
`define BP_FE_RAS_PKG_SV

`define DECLARE_BP_FE_RAS_CKPT_S(ras_ptr_width_p) \
  typedef struct packed { \
    logic [ras_ptr_width_p:0]   cnt; \
    logic [ras_ptr_width_p-1:0] tos; \
  } bp_fe_ras_ckpt_s

package bp_fe_ras_pkg;

  typedef enum logic [1:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_SWAP
  } ras_op_e;

  // A pop on an empty stack degrades to a nop,
  // and push+pop on an empty stack to a push.
  function automatic ras_op_e ras_op_decode(
    input logic push,
    input logic pop,
    input logic empty
  );
    ras_op_e op;
    op = RAS_NOP;
    unique case (1'b1)
      (push & pop & !empty):    op = RAS_SWAP;
      (push & !(pop & !empty)): op = RAS_PUSH;
      (!push & pop & !empty):   op = RAS_POP;
      default:                  op = RAS_NOP;
    endcase
    return op;
  endfunction

endpackage

`endif

// File: rtl/bp_fe_ras_ptr.sv
// Combinational next-state for RAS pointer/count/write/ovf.
// In: base tos/cnt, push/pop. Out: next tos/cnt, we, widx, ovf.
module bp_fe_ras_ptr
  import bp_fe_ras_pkg::*;
#(
  parameter int ras_els_p       = 8,
  parameter int ras_ptr_width_p = $clog2(ras_els_p)
) (
  input  logic [ras_ptr_width_p-1:0] i_base_tos,
  input  logic [ras_ptr_width_p:0]   i_base_cnt,
  input  logic                       i_push,
  input  logic                       i_pop,
  output logic [ras_ptr_width_p-1:0] o_tos,
  output logic [ras_ptr_width_p:0]   o_cnt,
  output logic                       o_we,
  output logic [ras_ptr_width_p-1:0] o_widx,
  output logic                       o_ovf
);

  localparam logic [ras_ptr_width_p:0] ELS =
    (ras_ptr_width_p+1)'(ras_els_p);

  logic    w_full;
  logic    w_empty;
  ras_op_e w_op;

  assign w_full  = (i_base_cnt == ELS);
  assign w_empty = (i_base_cnt == '0);
  assign w_op    = ras_op_decode(i_push, i_pop, w_empty);

  always_comb begin
    o_tos  = i_base_tos;
    o_cnt  = i_base_cnt;
    o_we   = 1'b0;
    o_widx = i_base_tos;
    o_ovf  = 1'b0;
    unique case (w_op)
      RAS_PUSH: begin
        // Pointer wraps for free: depth is a power of two.
        o_tos  = i_base_tos + 1'b1;
        o_widx = i_base_tos + 1'b1;
        o_we   = 1'b1;
        o_cnt  = w_full ? i_base_cnt : i_base_cnt + 1'b1;
        o_ovf  = w_full;
      end
      RAS_POP: begin
        o_tos = i_base_tos - 1'b1;
        o_cnt = i_base_cnt - 1'b1;
      end
      RAS_SWAP: begin
        o_we = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/bp_fe_ras.sv
// Checkpointable circular return address stack.
// push/pop from fetch, restore from redirect; top/ckpt/ovf out.
module bp_fe_ras
  import bp_fe_ras_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int ras_els_p       = 8,
  parameter int ras_ptr_width_p = $clog2(ras_els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       push_v_i,
  input  logic [vaddr_width_p-1:0]   push_addr_i,
  input  logic                       pop_v_i,
  output logic [vaddr_width_p-1:0]   top_addr_o,
  output logic                       top_v_o,
  output logic [ras_ptr_width_p-1:0] ckpt_tos_o,
  output logic [ras_ptr_width_p:0]   ckpt_cnt_o,
  input  logic                       restore_v_i,
  input  logic [ras_ptr_width_p-1:0] restore_tos_i,
  input  logic [ras_ptr_width_p:0]   restore_cnt_i,
  input  logic                       restore_call_i,
  input  logic                       restore_ret_i,
  input  logic [vaddr_width_p-1:0]   restore_addr_i,
  output logic                       ovf_o
);

  `DECLARE_BP_FE_RAS_CKPT_S(ras_ptr_width_p);

  logic [vaddr_width_p-1:0]   r_mem [ras_els_p];
  logic [ras_ptr_width_p-1:0] r_tos;
  logic [ras_ptr_width_p:0]   r_cnt;
  logic                       r_ovf;

  bp_fe_ras_ckpt_s            w_ckpt;
  bp_fe_ras_ckpt_s            w_base;
  logic                       w_push;
  logic                       w_pop;
  logic [vaddr_width_p-1:0]   w_addr;
  logic [ras_ptr_width_p-1:0] w_tos;
  logic [ras_ptr_width_p:0]   w_cnt;
  logic                       w_we;
  logic [ras_ptr_width_p-1:0] w_widx;
  logic                       w_ovf;

  assign w_ckpt = '{cnt: r_cnt, tos: r_tos};

  // A redirect overrides whatever fetch asks for.
  always_comb begin
    w_base = w_ckpt;
    w_push = push_v_i;
    w_pop  = pop_v_i;
    w_addr = push_addr_i;
    if (restore_v_i) begin
      w_base = '{cnt: restore_cnt_i, tos: restore_tos_i};
      w_push = restore_call_i;
      w_pop  = restore_ret_i;
      w_addr = restore_addr_i;
    end
  end

  bp_fe_ras_ptr #(
    .ras_els_p       (ras_els_p),
    .ras_ptr_width_p (ras_ptr_width_p)
  ) u_ptr (
    .i_base_tos (w_base.tos),
    .i_base_cnt (w_base.cnt),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .o_tos      (w_tos),
    .o_cnt      (w_cnt),
    .o_we       (w_we),
    .o_widx     (w_widx),
    .o_ovf      (w_ovf)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < ras_els_p; i++) begin
        r_mem[i] <= '0;
      end
      r_tos <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_tos <= w_tos;
      r_cnt <= w_cnt;
      r_ovf <= w_ovf;
      if (w_we) begin
        r_mem[w_widx] <= w_addr;
      end
    end
  end

  assign top_addr_o = r_mem[r_tos];
  assign top_v_o    = (r_cnt != '0);
  assign ckpt_tos_o = w_ckpt.tos;
  assign ckpt_cnt_o = w_ckpt.cnt;
  assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_bp_fe_ras.sv
// Self-checking bench for bp_fe_ras with a 4-entry stack.
// Reference model feeds an expected-state queue each cycle.
module tb_bp_fe_ras;

  localparam int VA  = 39;
  localparam int ELS = 4;
  localparam int PW  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          push_v;
  logic [VA-1:0] push_addr;
  logic          pop_v;
  logic [VA-1:0] top_addr;
  logic          top_v;
  logic [PW-1:0] ckpt_tos;
  logic [PW:0]   ckpt_cnt;
  logic          restore_v;
  logic [PW-1:0] restore_tos;
  logic [PW:0]   restore_cnt;
  logic          restore_call;
  logic          restore_ret;
  logic [VA-1:0] restore_addr;
  logic          ovf;

  always #5 clk = ~clk;

  bp_fe_ras #(
    .vaddr_width_p (VA),
    .ras_els_p     (ELS)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .push_v_i       (push_v),
    .push_addr_i    (push_addr),
    .pop_v_i        (pop_v),
    .top_addr_o     (top_addr),
    .top_v_o        (top_v),
    .ckpt_tos_o     (ckpt_tos),
    .ckpt_cnt_o     (ckpt_cnt),
    .restore_v_i    (restore_v),
    .restore_tos_i  (restore_tos),
    .restore_cnt_i  (restore_cnt),
    .restore_call_i (restore_call),
    .restore_ret_i  (restore_ret),
    .restore_addr_i (restore_addr),
    .ovf_o          (ovf)
  );

  always @(posedge clk) begin
    if (reset_n && restore_v) begin
      assert (restore_cnt <= 3'd4)
        else $error("illegal restore count %0d", restore_cnt);
    end
  end

  typedef struct {
    logic [VA-1:0] top;
    logic          v;
    logic [PW-1:0] tos;
    logic [PW:0]   cnt;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [VA-1:0] m_mem [ELS];
  logic [PW-1:0] m_tos;
  logic [PW:0]   m_cnt;
  logic          m_ovf;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < ELS; i++) m_mem[i] = '0;
    m_tos = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_op(input logic pu, input logic po,
                          input logic [VA-1:0] a,
                          input logic rv,
                          input logic [PW-1:0] rt,
                          input logic [PW:0] rc,
                          input logic rcall, input logic rret,
                          input logic [VA-1:0] ra);
    logic [PW-1:0] bt;
    logic [PW:0]   bc;
    logic          p, q;
    logic [VA-1:0] ad;
    bt = rv ? rt : m_tos;
    bc = rv ? rc : m_cnt;
    p  = rv ? rcall : pu;
    q  = rv ? rret : po;
    ad = rv ? ra : a;
    m_ovf = 1'b0;
    m_tos = bt;
    m_cnt = bc;
    if (p && q && bc != 3'd0) begin
      m_mem[bt] = ad;
    end else if (p) begin
      m_tos = bt + 2'd1;
      m_mem[m_tos] = ad;
      if (bc == 3'd4) m_ovf = 1'b1;
      else m_cnt = bc + 3'd1;
    end else if (q && bc != 3'd0) begin
      m_tos = bt - 2'd1;
      m_cnt = bc - 3'd1;
    end
  endtask

  task automatic cmp_out(input exp_t e, input string tag);
    chk({tag, ".top"}, 64'(top_addr), 64'(e.top));
    chk({tag, ".v"},   64'(top_v),    64'(e.v));
    chk({tag, ".tos"}, 64'(ckpt_tos), 64'(e.tos));
    chk({tag, ".cnt"}, 64'(ckpt_cnt), 64'(e.cnt));
    chk({tag, ".ovf"}, 64'(ovf),      64'(e.ovf));
  endtask

  task automatic drive(input string tag,
                       input logic pu, input logic po,
                       input logic [VA-1:0] a,
                       input logic rv,
                       input logic [PW-1:0] rt,
                       input logic [PW:0] rc,
                       input logic rcall, input logic rret,
                       input logic [VA-1:0] ra);
    exp_t e;
    push_v       = pu;
    pop_v        = po;
    push_addr    = a;
    restore_v    = rv;
    restore_tos  = rt;
    restore_cnt  = rc;
    restore_call = rcall;
    restore_ret  = rret;
    restore_addr = ra;
    model_op(pu, po, a, rv, rt, rc, rcall, rret, ra);
    e.top = m_mem[m_tos];
    e.v   = (m_cnt != 3'd0);
    e.tos = m_tos;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    push_v       = 1'b0;
    pop_v        = 1'b0;
    push_addr    = '0;
    restore_v    = 1'b0;
    restore_call = 1'b0;
    restore_ret  = 1'b0;
    restore_addr = '0;
    restore_tos  = '0;
    restore_cnt  = '0;
    if (sb.size() == 0) begin
      chk({tag, ".sb"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      cmp_out(e, tag);
    end
  endtask

  task automatic push(input string t, input logic [VA-1:0] a);
    drive(t, 1'b1, 1'b0, a, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic pop(input string t);
    drive(t, 1'b0, 1'b1, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic pushpop(input string t, input logic [VA-1:0] a);
    drive(t, 1'b1, 1'b1, a, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input string t);
    drive(t, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Mid-cycle async reset; outputs must clear before the next edge.
  task automatic async_reset(input string t);
    #2 reset_n = 1'b0;
    #1;
    cmp_out('{top: '0, v: 1'b0, tos: '0, cnt: '0, ovf: 1'b0}, t);
    model_clear();
    sb.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    push_v       = 1'b0;
    pop_v        = 1'b0;
    push_addr    = '0;
    restore_v    = 1'b0;
    restore_tos  = '0;
    restore_cnt  = '0;
    restore_call = 1'b0;
    restore_ret  = 1'b0;
    restore_addr = '0;
    model_clear();

    #2;
    cmp_out('{top: '0, v: 1'b0, tos: '0, cnt: '0, ovf: 1'b0}, "rst");
    repeat (2) @(posedge clk);
    #1;
    cmp_out('{top: '0, v: 1'b0, tos: '0, cnt: '0, ovf: 1'b0}, "rst_hold");
    reset_n = 1'b1;
    idle("idle0");
    idle("idle1");
    idle("idle2");

    push("lifo_p1", 39'h1000);
    push("lifo_p2", 39'h2000);
    push("lifo_p3", 39'h3000);
    chk("lifo_top3", 64'(top_addr), 64'h3000);
    chk("lifo_cnt3", 64'(ckpt_cnt), 64'd3);
    pop("lifo_q1");
    chk("lifo_top2", 64'(top_addr), 64'h2000);
    pop("lifo_q2");
    chk("lifo_top1", 64'(top_addr), 64'h1000);
    pop("lifo_q3");
    chk("lifo_empty", 64'(top_v), 64'd0);
    pop("lifo_under");
    chk("under_cnt", 64'(ckpt_cnt), 64'd0);
    chk("under_tos", 64'(ckpt_tos), 64'd0);

    for (int i = 1; i <= 5; i++) begin
      push($sformatf("ovf_p%0d", i), VA'(i * 16));
    end
    chk("ovf_cnt", 64'(ckpt_cnt), 64'd4);
    chk("ovf_top", 64'(top_addr), 64'h50);
    idle("ovf_gone");
    pop("ovf_q1");
    chk("ovf_top40", 64'(top_addr), 64'h40);
    pop("ovf_q2");
    pop("ovf_q3");
    chk("ovf_top20", 64'(top_addr), 64'h20);
    pop("ovf_q4");
    chk("ovf_empty", 64'(top_v), 64'd0);

    async_reset("arst0");
    push("pp_p1", 39'h1000);
    push("pp_p2", 39'h2000);
    pushpop("pp_swap", 39'h4000);
    chk("pp_top", 64'(top_addr), 64'h4000);
    chk("pp_cnt", 64'(ckpt_cnt), 64'd2);
    chk("pp_tos", 64'(ckpt_tos), 64'd2);
    pop("pp_q1");
    pop("pp_q2");
    pushpop("pp_empty", 39'h4000);
    chk("pp_e_cnt", 64'(ckpt_cnt), 64'd1);
    chk("pp_e_top", 64'(top_addr), 64'h4000);

    async_reset("arst1");
    drive("rs_seed", 1'b0, 1'b0, '0, 1'b1, 2'd3, 3'd0,
          1'b1, 1'b0, 39'h1000);
    push("rs_p2", 39'h2000);
    chk("rs_ck_tos", 64'(ckpt_tos), 64'd1);
    chk("rs_ck_cnt", 64'(ckpt_cnt), 64'd2);
    chk("rs_ck_top", 64'(top_addr), 64'h2000);
    push("rs_wp1", 39'h7000);
    push("rs_wp2", 39'h8000);
    drive("rs_ret", 1'b1, 1'b0, 39'h9000, 1'b1, 2'd1, 3'd2,
          1'b0, 1'b1, '0);
    chk("rs_ret_tos", 64'(ckpt_tos), 64'd0);
    chk("rs_ret_cnt", 64'(ckpt_cnt), 64'd1);
    chk("rs_ret_top", 64'(top_addr), 64'h1000);
    drive("rs_call", 1'b0, 1'b1, '0, 1'b1, 2'd1, 3'd2,
          1'b1, 1'b0, 39'hA000);
    chk("rs_call_top", 64'(top_addr), 64'hA000);
    chk("rs_call_cnt", 64'(ckpt_cnt), 64'd3);

    push("mid_p1", 39'h111);
    push("mid_p2", 39'h222);
    push("mid_p3", 39'h333);
    async_reset("mid_rst");
    idle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_fe_ras.md
# bp_fe_ras

Parametrised, multi-entry, checkpointable return address stack (RAS) for the BlackParrot front end. It replaces the single-register return address in PC generation with a circular stack of `ras_els_p` entries. Its top-of-stack pointer and count are checkpointed into branch metadata on every fetch, and are restored on a backend redirect. PC generation instantiates it: fetch-time call/ret scans drive push/pop, and redirect metadata drives restore.

## Interface
- `vaddr_width_p`, 39, virtual address width of stored return addresses.
- `ras_els_p`, 8, number of entries; must be a power of two and ≥2.
- `ras_ptr_width_p`, `$clog2(ras_els_p)`, derived; not to be overridden.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `push_v_i`  in  1  fetch detected a call; push `push_addr_i`.
- `push_addr_i`  in  vaddr_width_p  return address (call PC + 4).
- `pop_v_i`  in  1  fetch detected a ret; pop the top entry.
- `top_addr_o`  out  vaddr_width_p  `mem[tos_r]`, the predicted return target.
- `top_v_o`  out  1  `cnt_r != 0`.
- `ckpt_tos_o`  out  ras_ptr_width_p  current `tos_r`, to be stored in fetch branch metadata.
- `ckpt_cnt_o`  out  ras_ptr_width_p+1  current `cnt_r`, to be stored in fetch branch metadata.
- `restore_v_i`  in  1  backend redirect; restore the checkpoint.
- `restore_tos_i`  in  ras_ptr_width_p  checkpointed pointer.
- `restore_cnt_i`  in  ras_ptr_width_p+1  checkpointed count.
- `restore_call_i`  in  1  the redirected instruction is a call; push `restore_addr_i` after restoring.
- `restore_ret_i`  in  1  the redirected instruction is a ret; pop after restoring.
- `restore_addr_i`  in  vaddr_width_p  return address used for the restore push.
- `ovf_o`  out  1  registered one-cycle pulse: the previous cycle's push overwrote the oldest entry.

## Operation
- **State:**
  - `mem[ras_els_p]` of vaddr_width_p bits.
  - `tos_r`, index of the top entry.
  - `cnt_r`, range 0..ras_els_p.
  - `ovf_r`.
- **Async reset:** all `mem` entries = 0, `tos_r` = 0, `cnt_r` = 0, `ovf_r` = 0.
  - Reset output values: `top_addr_o` = 0, `top_v_o` = 0, `ckpt_tos_o` = 0, `ckpt_cnt_o` = 0, `ovf_o` = 0.
- **Effective operation:**
  - If `restore_v_i`: base = (`restore_tos_i`, `restore_cnt_i`), op = (`restore_call_i`, `restore_ret_i`, `restore_addr_i`). `push_v_i` and `pop_v_i` are ignored.
  - Otherwise: base = (`tos_r`, `cnt_r`), op = (`push_v_i`, `pop_v_i`, `push_addr_i`).
- **Op rules, applied to the base:**
  - Push only:
    - `tos` = base+1 mod `ras_els_p`; `mem[tos]` = addr; `cnt` = min(base_cnt+1, `ras_els_p`).
    - If base_cnt == `ras_els_p`, the oldest entry is overwritten and `ovf_r` is set for one cycle.
  - Pop only:
    - If base_cnt > 0: `tos` = base−1 mod `ras_els_p`; `cnt` = base_cnt−1.
    - If base_cnt == 0: underflow, ignored; `tos` and `cnt` equal the base. No error is raised.
  - Push and pop together:
    - If base_cnt > 0: replace in place, `mem[base_tos]` = addr; `tos` and `cnt` unchanged.
    - If base_cnt == 0: behaves as push only.
  - Neither: `tos` and `cnt` equal the base. This covers a restore with no op.
- **Restore scope:** restore repairs pointers only. Entries overwritten by wrong-path pushes are not repaired; this prediction loss is accepted.
- **Restore input range:** `restore_cnt_i` > `ras_els_p` is illegal. The bench asserts on it; the design does not check it.

## Timing
- `top_addr_o`, `top_v_o`, `ckpt_*_o` are combinational from registered state only. There is no input-to-output combinational path.
- Push, pop, and restore effects are visible on the outputs in the cycle after they are asserted, i.e. 1-cycle latency.
- `ckpt_*_o` in cycle N reflect state before cycle N's operation. PC generation therefore checkpoints the pre-call/pre-ret state.
- `ovf_o` asserts in cycle N+1 for an overflowing push in cycle N, and lasts exactly one cycle.
- No handshake: all inputs are valid-only and always accepted.
- Reset asserted mid-operation clears state immediately, without a clock edge. The first update occurs on the first rising edge after `reset_n_i` deasserts.

## Structure
- `bp_fe_pkg` adds the macro `declare_bp_fe_ras_ckpt_s(ras_ptr_width_p)`, fields `tos` and `cnt`. It is embedded in `bp_fe_branch_metadata_fwd_s`; metadata width grows accordingly.
- One sub-module, `bp_fe_ras_ptr`:
  - Purely combinational next-state logic for `tos`/`cnt`/write-enable/ovf, from base and op.
  - Instantiated once.
- Storage is a flop array with async reset in the top module. A 1r1w RAM is not used, because of the async reset and the same-cycle read of top.

## Test plan
- **Reset:** with `ras_els_p`=4, hold `reset_n_i`=0 → all outputs 0. Release, idle 3 cycles → outputs remain 0.
- **LIFO:**
  - Push 0x1000, 0x2000, 0x3000 on consecutive cycles → `top_addr_o` = 0x3000, `cnt` = 3.
  - Three pops → top reads 0x2000, then 0x1000, then `top_v_o` = 0.
  - A fourth pop → `tos` and `cnt` unchanged.
- **Overflow:**
  - Push A1..A5 (0x10..0x50) → `cnt` = 4; `ovf_o` pulses exactly once, in the cycle after the A5 push.
  - Pops return 0x50, 0x40, 0x30, 0x20, then `top_v_o` = 0.
- **Simultaneous push+pop:** top = 0x2000, `cnt` = 2; push 0x4000 with pop → `top_addr_o` = 0x4000, `cnt` = 2, `tos` unchanged. Repeat with `cnt` = 0 → `cnt` = 1, top = 0x4000.
- **Restore:**
  - Start from state (`tos`=1, `cnt`=2, top 0x2000) and capture the checkpoint. Push 0x7000 and 0x8000 (wrong path).
  - Assert `restore_v_i` with the checkpoint and `restore_ret_i`=1, while `push_v_i`=1 with 0x9000 → next cycle `tos` = 0, `cnt` = 1, top = 0x1000.
  - Repeat with `restore_call_i` and addr 0xA000 → top = 0xA000, `cnt` = 3.
- **Async reset mid-stream:** after 3 pushes, drop `reset_n_i` between clock edges → outputs go to 0 before the next edge.
